systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/gemm_pkg.sv | 29 ++
 rtl/skew_delay_line.sv | 40 ++++
 rtl/systolic_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_feeder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gemm_pkg
//  Description : Shared definitions for the GEMM datapath: default operand
//                width and array edge length, the feeder state encoding, the
//                16-bit count type and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

    localparam int GEMM_DATA_WIDTH = 8;
    localparam int GEMM_N          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_e;

    typedef logic [15:0] count_t;

    localparam count_t COUNT_MAX = 16'hFFFF;

    function automatic count_t sat_inc(input count_t v);
        return (v == COUNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : DEPTH-stage shift register used to skew one systolic lane.
//                Output is the input delayed by exactly DEPTH clocks.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low clear of every stage
//                i_data   - lane value entering the line
//                o_data   - lane value leaving the line
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_feeder
//  Description : Accepts a tile of k_len operand vectors and drives them into
//                a systolic array edge with a diagonal skew: lane i of a
//                vector accepted at cycle t appears on edge_out during cycle
//                t+1+i. Bubbles and idle slots carry zero. done pulses when
//                the last lane of the last vector is on edge_out.
//  Ports       : clk, reset_n (async, active-low)
//                start, k_len         - tile request (honoured only in IDLE)
//                in_valid/in_ready    - vector handshake, in_data packed lanes
//                edge_out             - skewed lanes, same packing as in_data
//                busy, done           - status
//                bubble_cnt           - optional, STREAM bubbles (saturating)
//  Config      : `define SYSTOLIC_FEEDER_BUBBLE_CNT_EN adds bubble_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH = GEMM_DATA_WIDTH,
    parameter int N          = GEMM_N
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [15:0]             k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [N*DATA_WIDTH-1:0] edge_out,
    output logic                    busy,
    output logic                    done
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]             bubble_cnt
`endif
);

    // Flush lasts N cycles; counter must hold 0..N-1.
    localparam int FLUSH_W = (N > 1) ? $clog2(N) : 1;

    feeder_state_e          r_state;
    count_t                 r_remaining;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic                   r_zero_done;

    logic                    w_accept;
    logic                    w_flush_done;
    logic [N*DATA_WIDTH-1:0] w_inject;

    // Handshake and status are pure decodes of registered state.
    assign in_ready     = (r_state == ST_STREAM);
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = in_ready && in_valid;
    assign w_flush_done = (r_state == ST_FLUSH) &&
                          (r_flush_cnt == FLUSH_W'(N-1));
    assign done         = w_flush_done || r_zero_done;

    // Everything not accepted enters the skew pipeline as zero.
    assign w_inject = w_accept ? in_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_flush_cnt <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (k_len == 16'd0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state     <= ST_STREAM;
                            r_remaining <= k_len;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane i is delayed i+1 cycles to form the diagonal wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (i + 1)
        ) u_skew (
            .clk     (clk),
            .reset_n (reset_n),
            .i_data  (w_inject[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_data  (edge_out[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end : g_lane

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    count_t r_bubble_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_bubble_cnt <= '0;
        end else if ((r_state == ST_STREAM) && !in_valid) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_feeder
//  Description : Self-checking bench for systolic_feeder (N=4, DATA_WIDTH=8).
//                Accepted vectors push per-lane expected slots into a
//                scoreboard; a negedge monitor pops and compares edge_out.
//                Control outputs are checked inline by each scenario task.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [15:0]     k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic [N*DW-1:0] edge_out;
    logic            busy;
    logic            done;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    logic [15:0]     bubble_cnt;
`endif

    systolic_feeder #(
        .DATA_WIDTH (DW),
        .N          (N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .edge_out (edge_out),
        .busy     (busy),
        .done     (done)
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        int          lane;
        logic [DW-1:0] val;
    } slot_t;

    slot_t           sb[$];
    bit              mon_en = 1'b0;
    logic [N*DW-1:0] mon_exp;

    // Monitor: every lane slot without a scoreboard entry must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = '0;
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].cyc == cyc) begin
                    mon_exp[sb[j].lane*DW +: DW] = sb[j].val;
                    sb.delete(j);
                end
            end
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (edge_out[i*DW +: DW] !== mon_exp[i*DW +: DW]) begin
                    n_fail++;
                    $display("FAIL edge_out lane%0d cycle %0d: got %h expected %h",
                             i, cyc, edge_out[i*DW +: DW], mon_exp[i*DW +: DW]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called during the cycle a vector is accepted: lane i is due at cyc+1+i.
    task automatic push_vec(input logic [N*DW-1:0] v);
        for (int i = 0; i < N; i++) begin
            sb.push_back('{cyc: cyc + 1 + i, lane: i, val: v[i*DW +: DW]});
        end
    endtask

    // One complete tile: start, k vectors (optional single bubble after
    // vector index bubble_after), then flush. With start_busy, start is
    // also raised during STREAM, the first FLUSH cycle and the done cycle.
    task automatic run_tile(input int k, input int bubble_after,
                            input bit start_busy, input logic [N*DW-1:0] first_vec);
        int              sent;
        int              t_last;
        bit              bubbled;
        logic [N*DW-1:0] v;
        next_cycle();
        start = 1'b1; k_len = 16'(k); in_valid = 1'b0; in_data = $urandom;
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_cycle busy/ready/done: got %b expected 000",
                     {busy, in_ready, done});
        end
        sent = 0; bubbled = 1'b0; t_last = -1;
        while (sent < k) begin
            next_cycle();
            start = start_busy; k_len = 16'd7;
            if (!bubbled && bubble_after >= 0 && sent == bubble_after + 1) begin
                in_valid = 1'b0; in_data = $urandom; bubbled = 1'b1;
            end else begin
                v = (sent == 0) ? first_vec : $urandom;
                in_valid = 1'b1; in_data = v;
                push_vec(v);
                sent++;
                if (sent == k) t_last = cyc;
            end
            @(negedge clk);
            n_checks++;
            if ({busy, in_ready, done} !== 3'b110) begin
                n_fail++;
                $display("FAIL stream busy/ready/done cycle %0d: got %b expected 110",
                         cyc, {busy, in_ready, done});
            end
        end
        for (int c = 1; c <= N + 2; c++) begin
            next_cycle();
            in_valid = 1'b1; in_data = $urandom;
            start = start_busy && (c == 1 || c == N); k_len = 16'd2;
            @(negedge clk);
            n_checks++;
            if ({busy, in_ready, done} !==
                {(cyc <= t_last + N), 1'b0, (cyc == t_last + N)}) begin
                n_fail++;
                $display("FAIL flush busy/ready/done cycle %0d (t_last %0d): got %b expected %b",
                         cyc, t_last, {busy, in_ready, done},
                         {(cyc <= t_last + N), 1'b0, (cyc == t_last + N)});
            end
        end
        next_cycle();
        start = 1'b0; in_valid = 1'b0;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
        n_checks++;
        if (bubble_cnt !== 16'(bubbled)) begin
            n_fail++;
            $display("FAIL bubble_cnt: got %0d expected %0d", bubble_cnt, bubbled);
        end
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; in_data = '0;
        #2;
        n_checks++;
        if ({edge_out, busy, in_ready, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got edge %h b/r/d %b expected all 0",
                     edge_out, {busy, in_ready, done});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({edge_out, busy, in_ready, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got edge %h b/r/d %b expected all 0",
                     edge_out, {busy, in_ready, done});
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic test_single();
        run_tile(1, -1, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1});
    endtask

    task automatic test_back_to_back();
        run_tile(3, -1, 1'b0, $urandom);
    endtask

    task automatic test_bubble();
        run_tile(2, 0, 1'b0, $urandom);
    endtask

    task automatic test_zero_len();
        next_cycle();
        start = 1'b1; k_len = 16'd0; in_valid = 1'b1; in_data = $urandom;
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_len start cycle: got %b expected 000", {busy, in_ready, done});
        end
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL zero_len done cycle: got %b expected 001", {busy, in_ready, done});
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({busy, in_ready, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL zero_len after: got %b expected 000", {busy, in_ready, done});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_neg_and_busy_start();
        run_tile(3, -1, 1'b1, {8'h80, 8'h7F, 8'h80, 8'hFF});
    endtask

    task automatic test_mid_reset();
        logic [N*DW-1:0] v;
        next_cycle();
        start = 1'b1; k_len = 16'd4; in_valid = 1'b0;
        next_cycle();
        start = 1'b0; v = $urandom; in_valid = 1'b1; in_data = v; push_vec(v);
        next_cycle();
        v = $urandom; in_data = v; push_vec(v);
        next_cycle();
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if ({edge_out, busy, in_ready, done} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got edge %h b/r/d %b expected all 0",
                     edge_out, {busy, in_ready, done});
        end
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL after_reset busy/done: got %b expected 00", {busy, done});
            end
        end
        run_tile(2, -1, 1'b0, $urandom);
    endtask

    task automatic test_max_len();
        run_tile(65535, -1, 1'b0, $urandom);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bubble();
        test_zero_len();
        test_neg_and_busy_start();
        test_mid_reset();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
